// File: rtl/instr_fetch_unit_if.sv
// Fetch unit bus bundle: instruction memory request/response, the
// decode-side instruction handshake and the branch/jump redirect port.
interface instr_fetch_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;
    logic        redirect_valid;
    logic        redirect_kind;
    logic [31:0] redirect_base_pc;
    logic [25:0] redirect_imm;

    // Fetch unit side
    modport master (
        output imem_req, imem_addr, instr_valid, instr, instr_pc,
        input  imem_ready, imem_rvalid, imem_rdata, instr_ready,
        input  redirect_valid, redirect_kind, redirect_base_pc, redirect_imm
    );

    // Memory / decode / branch-resolution side
    modport slave (
        input  imem_req, imem_addr, instr_valid, instr, instr_pc,
        output imem_ready, imem_rvalid, imem_rdata, instr_ready,
        output redirect_valid, redirect_kind, redirect_base_pc, redirect_imm
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: single-outstanding memory fetcher feeding a small
// FIFO of {instr, pc} toward decode, with branch/jump redirect and a discard
// flag that swallows the one response belonging to a pre-redirect request.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          BUF_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    instr_fetch_unit_if.master    bus
);

    localparam int              PTR_W    = (BUF_DEPTH > 2) ? $clog2(BUF_DEPTH) : 1;
    localparam int              CNT_W    = $clog2(BUF_DEPTH + 1);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(BUF_DEPTH - 1);
    localparam logic [PTR_W-1:0] PTR_ZERO = {PTR_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } state_t;

    state_t            state_r, state_s;
    logic [31:0]       fetch_pc_r, fetch_pc_s;
    logic [31:0]       addr_r, addr_s;
    logic              req_r;
    logic              valid_r;
    logic              discard_r, discard_s;
    logic [31:0]       data_r [BUF_DEPTH];
    logic [31:0]       pcq_r  [BUF_DEPTH];
    logic [PTR_W-1:0]  head_r, head_s;
    logic [PTR_W-1:0]  tail_r, tail_s;
    logic [CNT_W-1:0]  count_r, count_s;
    logic              accept_s;
    logic              rsp_s;
    logic              push_s;
    logic              pop_s;
    logic [31:0]       target_s;

    // Circular pointer advance for a depth that need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        logic [PTR_W-1:0] r;
        if (p == PTR_LAST) begin
            r = PTR_ZERO;
        end else begin
            r = p + PTR_W'(1);
        end
        return r;
    endfunction

    // beq: sign-extended word offset relative to the delay-slot PC
    function automatic logic [31:0] branch_target(input logic [31:0] base, input logic [25:0] imm);
        logic [31:0] seq;
        seq = base + 32'd4;
        return seq + {{14{imm[15]}}, imm[15:0], 2'b00};
    endfunction

    // j: pseudo-direct address inside the 256 MB region of the next PC
    function automatic logic [31:0] jump_target(input logic [31:0] base, input logic [25:0] imm);
        logic [31:0] seq;
        seq = base + 32'd4;
        return {seq[31:28], imm, 2'b00};
    endfunction

    // Next-state, buffer bookkeeping, fetch PC and discard flag
    always_comb begin
        accept_s  = (state_r == REQ) && bus.imem_ready;
        rsp_s     = (state_r == WAIT) && bus.imem_rvalid;
        push_s    = rsp_s && !discard_r;
        pop_s     = (count_r != CNT_ZERO) && bus.instr_ready;
        target_s  = bus.redirect_kind ? jump_target(bus.redirect_base_pc, bus.redirect_imm)
                                      : branch_target(bus.redirect_base_pc, bus.redirect_imm);
        head_s    = head_r;
        tail_s    = tail_r;
        count_s   = count_r;
        state_s   = state_r;

        // A redirect flushes the buffer and wins over any push or pop
        if (bus.redirect_valid) begin
            head_s  = PTR_ZERO;
            tail_s  = PTR_ZERO;
            count_s = CNT_ZERO;
        end else begin
            if (push_s) begin
                tail_s = ptr_inc(tail_r);
            end else begin
                tail_s = tail_r;
            end
            if (pop_s) begin
                head_s = ptr_inc(head_r);
            end else begin
                head_s = head_r;
            end
            case ({push_s, pop_s})
                2'b10:   count_s = count_r + CNT_ONE;
                2'b01:   count_s = count_r - CNT_ONE;
                default: count_s = count_r;
            endcase
        end

        if (bus.redirect_valid) begin
            fetch_pc_s = target_s;
        end else if (push_s) begin
            fetch_pc_s = fetch_pc_r + 32'd4;
        end else begin
            fetch_pc_s = fetch_pc_r;
        end

        // Only a request that will still be in flight after this edge needs discarding;
        // a response landing on the redirect edge completes the old request itself
        if (bus.redirect_valid) begin
            discard_s = (state_r == REQ) || ((state_r == WAIT) && !bus.imem_rvalid);
        end else if (rsp_s) begin
            discard_s = 1'b0;
        end else begin
            discard_s = discard_r;
        end

        // count_s already reflects push/pop/flush, so a response never finds the buffer full
        case (state_r)
            IDLE: begin
                if (count_s < CNT_FULL) begin
                    state_s = REQ;
                end else begin
                    state_s = IDLE;
                end
            end
            REQ: begin
                if (accept_s) begin
                    state_s = WAIT;
                end else begin
                    state_s = REQ;
                end
            end
            WAIT: begin
                if (bus.imem_rvalid) begin
                    if (count_s < CNT_FULL) begin
                        state_s = REQ;
                    end else begin
                        state_s = IDLE;
                    end
                end else begin
                    state_s = WAIT;
                end
            end
            default: state_s = IDLE;
        endcase

        // A presented request keeps its address until accepted, redirect or not
        if ((state_r == REQ) && !accept_s) begin
            addr_s = addr_r;
        end else begin
            addr_s = fetch_pc_s;
        end
    end

    // Control state, pointers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            fetch_pc_r <= RESET_PC;
            addr_r     <= RESET_PC;
            req_r      <= 1'b0;
            valid_r    <= 1'b0;
            discard_r  <= 1'b0;
            head_r     <= PTR_ZERO;
            tail_r     <= PTR_ZERO;
            count_r    <= CNT_ZERO;
        end else begin
            state_r    <= state_s;
            fetch_pc_r <= fetch_pc_s;
            addr_r     <= addr_s;
            req_r      <= (state_s == REQ);
            valid_r    <= (count_s != CNT_ZERO);
            discard_r  <= discard_s;
            head_r     <= head_s;
            tail_r     <= tail_s;
            count_r    <= count_s;
        end
    end

    // Instruction buffer storage, written at the tail on an accepted response
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < BUF_DEPTH; i++) begin
                data_r[i] <= 32'h0000_0000;
                pcq_r[i]  <= 32'h0000_0000;
            end
        end else begin
            if (push_s && !bus.redirect_valid) begin
                data_r[tail_r] <= bus.imem_rdata;
                pcq_r[tail_r]  <= fetch_pc_r;
            end else begin
                data_r[tail_r] <= data_r[tail_r];
                pcq_r[tail_r]  <= pcq_r[tail_r];
            end
        end
    end

    assign bus.imem_req    = req_r;
    assign bus.imem_addr   = addr_r;
    assign bus.instr_valid = valid_r;
    assign bus.instr       = data_r[head_r];
    assign bus.instr_pc    = pcq_r[head_r];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Bench for instr_fetch_unit: directed scenarios plus a randomized phase,
// with a memory responder and an expected-PC-stream model of decode's view.
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk;
    logic rst_n;
    instr_fetch_unit_if bus ();

    instr_fetch_unit #(.RESET_PC(RESET_PC), .BUF_DEPTH(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          cyc, n_pops, n_acc;
    int          lat_min, lat_max, rdy_pct, irdy_pct;
    logic        out_pend;
    logic [31:0] out_addr;
    int          out_wait;
    logic        inj_rvalid;
    logic        redir_pend, redir_kind_q;
    logic [31:0] redir_base_q;
    logic [25:0] redir_imm_q;
    logic [31:0] exp_pc;
    logic        last_redir;
    logic        prev_req, prev_rdy, prev_iv, prev_irdy;
    logic [31:0] prev_addr, prev_ipc, prev_ins;
    logic        seen_req;
    logic [31:0] first_req_addr, last_pop_pc;
    logic        s_req, s_iv;
    logic        tr_req [0:15];
    logic [31:0] tr_addr [0:15];
    logic        tr_iv [0:15];
    logic [31:0] tr_ipc [0:15];

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_C3C3;
    endfunction

    // Redirect target straight from the ISA description using plain arithmetic
    function automatic logic [31:0] model_target(input logic kind, input logic [31:0] base,
                                                 input logic [25:0] imm);
        logic [31:0]        nxt;
        logic signed [15:0] off16;
        int                 offs;
        nxt = base + 32'd4;
        if (kind) return (nxt & 32'hF000_0000) | ({6'd0, imm} << 2);
        off16 = imm[15:0];
        offs  = off16;
        return nxt + 32'(offs * 4);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
    endtask

    task automatic redirect(input logic kind, input logic [31:0] base, input logic [25:0] imm);
        redir_pend   = 1'b1;
        redir_kind_q = kind;
        redir_base_q = base;
        redir_imm_q  = imm;
    endtask

    // One clock: sample at negedge, check, then drive inputs for the next posedge
    task automatic step();
        logic        req_v, iv_v, rdy, irdy;
        logic [31:0] addr_v, ins_v, ipc_v;
        @(negedge clk);
        req_v = bus.imem_req;  addr_v = bus.imem_addr;
        iv_v  = bus.instr_valid; ins_v = bus.instr; ipc_v = bus.instr_pc;
        s_req = req_v; s_iv = iv_v;
        cyc++;
        if (cyc < 16) begin
            tr_req[cyc] = req_v; tr_addr[cyc] = addr_v; tr_iv[cyc] = iv_v; tr_ipc[cyc] = ipc_v;
        end
        chk("one_outstanding", {31'd0, req_v & out_pend}, 32'd0);
        chk("addr_aligned", {30'd0, addr_v[1:0]}, 32'd0);
        if (prev_req && !prev_rdy) begin
            chk("req_hold", {31'd0, req_v}, 32'd1);
            chk("addr_hold", addr_v, prev_addr);
        end
        if (last_redir) chk("flush_valid", {31'd0, iv_v}, 32'd0);
        if (prev_iv && !prev_irdy && !last_redir) begin
            chk("head_hold_valid", {31'd0, iv_v}, 32'd1);
            chk("head_hold_pc", ipc_v, prev_ipc);
            chk("head_hold_instr", ins_v, prev_ins);
        end
        if (req_v && !seen_req) begin
            seen_req = 1'b1;
            first_req_addr = addr_v;
        end
        // memory responder
        bus.imem_rvalid = 1'b0;
        bus.imem_rdata  = 32'h0000_0000;
        if (out_pend) begin
            if (out_wait == 0) begin
                bus.imem_rvalid = 1'b1;
                bus.imem_rdata  = mem_word(out_addr);
                out_pend = 1'b0;
            end else begin
                out_wait--;
            end
        end else if (inj_rvalid) begin
            bus.imem_rvalid = 1'b1;
            bus.imem_rdata  = 32'hDEAD_BEEF;
        end
        inj_rvalid = 1'b0;
        rdy = ($urandom_range(99, 0) < rdy_pct);
        bus.imem_ready = rdy;
        if (req_v && rdy) begin
            out_pend = 1'b1;
            out_addr = addr_v;
            out_wait = $urandom_range(lat_max, lat_min);
            n_acc++;
        end
        prev_req = req_v; prev_rdy = rdy; prev_addr = addr_v;
        // decode consumer and expected stream
        irdy = ($urandom_range(99, 0) < irdy_pct);
        bus.instr_ready = irdy;
        if (iv_v && irdy) begin
            chk("pop_pc", ipc_v, exp_pc);
            chk("pop_instr", ins_v, mem_word(exp_pc));
            last_pop_pc = ipc_v;
            n_pops++;
            exp_pc = exp_pc + 32'd4;
        end
        prev_iv = iv_v; prev_irdy = irdy; prev_ipc = ipc_v; prev_ins = ins_v;
        if (redir_pend) begin
            bus.redirect_valid   = 1'b1;
            bus.redirect_kind    = redir_kind_q;
            bus.redirect_base_pc = redir_base_q;
            bus.redirect_imm     = redir_imm_q;
            exp_pc     = model_target(redir_kind_q, redir_base_q, redir_imm_q);
            last_redir = 1'b1;
            redir_pend = 1'b0;
            seen_req   = 1'b0;
        end else begin
            bus.redirect_valid = 1'b0;
            last_redir = 1'b0;
        end
    endtask

    task automatic clear_model();
        out_pend = 1'b0; inj_rvalid = 1'b0; redir_pend = 1'b0;
        exp_pc = RESET_PC; last_redir = 1'b0; seen_req = 1'b0;
        prev_req = 1'b0; prev_rdy = 1'b0; prev_iv = 1'b0; prev_irdy = 1'b0;
        cyc = 0;
    endtask

    task automatic drive_idle_inputs();
        bus.imem_ready = 1'b0; bus.imem_rvalid = 1'b0; bus.imem_rdata = 32'h0000_0000;
        bus.instr_ready = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_kind = 1'b0;
        bus.redirect_base_pc = 32'h0000_0000; bus.redirect_imm = 26'h0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive_idle_inputs();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("rst_addr", bus.imem_addr, RESET_PC);
        chk("rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("rst_instr", bus.instr, 32'd0);
        chk("rst_pc", bus.instr_pc, 32'd0);
        clear_model();
        rst_n = 1'b1;
    endtask

    task automatic wait_pop();
        int p0;
        int k;
        p0 = n_pops;
        k  = 0;
        while (n_pops == p0 && k < 200) begin
            step();
            k++;
        end
        chk("pop_timeout", {31'd0, (n_pops != p0)}, 32'd1);
    endtask

    task automatic wait_first_req();
        int k;
        k = 0;
        while (!seen_req && k < 20) begin
            step();
            k++;
        end
        chk("req_timeout", {31'd0, seen_req}, 32'd1);
    endtask

    initial begin
        int acc0, p0, k;
        rst_n = 1'b0;
        drive_idle_inputs();
        n_pops = 0; n_acc = 0; out_wait = 0; out_addr = 32'h0;
        last_pop_pc = 32'h0; first_req_addr = 32'h0;
        lat_min = 0; lat_max = 0; rdy_pct = 100; irdy_pct = 100;
        clear_model();

        // zero-latency streaming from reset: fetches at cycles 1, 3, 5
        do_reset();
        repeat (6) step();
        chk("c1_req", {31'd0, tr_req[1]}, 32'd1);
        chk("c1_addr", tr_addr[1], 32'h0000_0000);
        chk("c2_req", {31'd0, tr_req[2]}, 32'd0);
        chk("c2_valid", {31'd0, tr_iv[2]}, 32'd0);
        chk("c3_req", {31'd0, tr_req[3]}, 32'd1);
        chk("c3_addr", tr_addr[3], 32'h0000_0004);
        chk("c3_valid", {31'd0, tr_iv[3]}, 32'd1);
        chk("c3_pc", tr_ipc[3], 32'h0000_0000);
        chk("c5_addr", tr_addr[5], 32'h0000_0008);

        // decode stalled: only two requests fit in the buffer
        irdy_pct = 0;
        do_reset();
        acc0 = n_acc;
        repeat (20) step();
        chk("stall_req_count", 32'(n_acc - acc0), 32'd2);
        chk("stall_req_low", {31'd0, s_req}, 32'd0);
        chk("stall_valid", {31'd0, s_iv}, 32'd1);
        irdy_pct = 100;
        p0 = n_pops;
        repeat (12) step();
        chk("drain_pops", {31'd0, (n_pops - p0 >= 4)}, 32'd1);

        // branch redirect from an idle, full buffer
        irdy_pct = 0;
        repeat (10) step();
        redirect(1'b0, 32'h0000_0010, 26'h000FFFC);
        step();
        wait_first_req();
        chk("branch_fetch_addr", first_req_addr, 32'h0000_0004);
        irdy_pct = 100;
        wait_pop();
        chk("branch_first_pc", last_pop_pc, 32'h0000_0004);

        // jump redirect
        irdy_pct = 0;
        repeat (10) step();
        redirect(1'b1, 32'h3000_0000, 26'h0000100);
        step();
        wait_first_req();
        chk("jump_fetch_addr", first_req_addr, 32'h3000_0400);
        irdy_pct = 100;
        wait_pop();
        chk("jump_first_pc", last_pop_pc, 32'h3000_0400);

        // redirect while waiting, response arrives later
        lat_min = 3; lat_max = 3;
        k = 0;
        while (!(out_pend && out_wait > 0) && k < 50) begin step(); k++; end
        chk("reach_wait_late", {31'd0, (out_pend && out_wait > 0)}, 32'd1);
        redirect(1'b0, 32'h0000_0100, 26'h0000010);
        step();
        wait_pop();
        chk("wait_redirect_pc", last_pop_pc, 32'h0000_0144);

        // redirect on the same edge as the response
        lat_min = 0; lat_max = 0;
        k = 0;
        while (!(out_pend && out_wait == 0) && k < 50) begin step(); k++; end
        chk("reach_wait_same", {31'd0, (out_pend && out_wait == 0)}, 32'd1);
        redirect(1'b1, 32'h0000_2000, 26'h0000040);
        step();
        wait_pop();
        chk("same_edge_redirect_pc", last_pop_pc, 32'h0000_0100);

        // fetch PC wraps past the top of the address space
        redirect(1'b1, 32'hF000_0000, 26'h3FFFFFF);
        step();
        wait_pop();
        chk("wrap_first_pc", last_pop_pc, 32'hFFFF_FFFC);
        wait_pop();
        chk("wrap_second_pc", last_pop_pc, 32'h0000_0000);

        // stray response while idle is ignored
        irdy_pct = 0;
        repeat (10) step();
        inj_rvalid = 1'b1;
        step();
        repeat (3) step();
        irdy_pct = 100;
        repeat (8) step();

        // randomized traffic with occasional redirects
        lat_min = 0; lat_max = 3; rdy_pct = 70; irdy_pct = 60;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(31, 0) == 0) begin
                redirect(1'($urandom_range(1, 0)), $urandom & 32'hFFFF_FFFC, 26'($urandom));
            end
            step();
        end
        rdy_pct = 100; irdy_pct = 100;
        wait_pop();

        // asynchronous reset in the middle of a delayed response
        lat_min = 5; lat_max = 5;
        k = 0;
        while (!(out_pend && out_wait >= 2) && k < 50) begin step(); k++; end
        chk("reach_wait_reset", {31'd0, (out_pend && out_wait >= 2)}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_rst_req", {31'd0, bus.imem_req}, 32'd0);
        chk("async_rst_addr", bus.imem_addr, RESET_PC);
        chk("async_rst_valid", {31'd0, bus.instr_valid}, 32'd0);
        chk("async_rst_instr", bus.instr, 32'd0);
        chk("async_rst_pc", bus.instr_pc, 32'd0);
        clear_model();
        drive_idle_inputs();
        @(negedge clk);
        rst_n = 1'b1;
        lat_min = 0; lat_max = 0; rdy_pct = 0;
        step();
        chk("post_rst_req", {31'd0, tr_req[1]}, 32'd1);
        chk("post_rst_addr", tr_addr[1], RESET_PC);
        inj_rvalid = 1'b1;
        step();
        rdy_pct = 100;
        wait_pop();
        chk("post_rst_first_pc", last_pop_pc, RESET_PC);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
